// File: rtl/sub_bytes2.sv
// sub_bytes2: registered AES SubBytes stage, forward Rijndael S-box on all 16 bytes of the state.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset; clears outstate and out_valid
//   in_valid  - instate carries a valid state this cycle
//   instate   - 128-bit state before substitution
//   outstate  - 128-bit substituted state, registered, held while no new input
//   out_valid - outstate holds a new result this cycle
module sub_bytes2 (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [127:0] instate,
   output logic [127:0] outstate,
   output logic         out_valid
);
   // Row = high nibble, column = low nibble.
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
   logic [127:0] sub;
   for (genvar k = 0; k < 16; k++) begin : g_byte
      assign sub[8*k +: 8] = SBOX[instate[8*k +: 8]];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outstate  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) outstate <= sub;
      end
   end
endmodule

// File: tb/tb_sub_bytes2.sv
// tb_sub_bytes2: self-checking bench for sub_bytes2 against an S-box derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes2;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [127:0] instate;
   logic [127:0] outstate;
   logic         out_valid;
   logic [127:0] exp_out;
   logic         exp_valid;
   logic [7:0]   ref_tab [0:255];
   int           n_assert = 0;
   int           n_fail = 0;

   sub_bytes2 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instate(instate),
      .outstate(outstate), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [7:0] sbox_math(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_ref(input logic [127:0] s);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[s[8*k +: 8]];
      return r;
   endfunction

   task automatic check_model(input string tag);
      n_assert++;
      assert (out_valid === exp_valid) else begin
         n_fail++;
         $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_valid);
      end
      n_assert++;
      assert (outstate === exp_out) else begin
         n_fail++;
         $error("FAIL %s outstate observed=%h expected=%h", tag, outstate, exp_out);
      end
   endtask

   task automatic check_lit(input string tag, input logic [127:0] val, input logic vld);
      n_assert++;
      assert (outstate === val && out_valid === vld) else begin
         n_fail++;
         $error("FAIL %s observed=%h/%b expected=%h/%b", tag, outstate, out_valid, val, vld);
      end
   endtask

   // Advance one clock edge, updating the expected outputs from the inputs presented at that edge.
   task automatic tick(input string tag);
      if (!rst_n) begin
         exp_out   = '0;
         exp_valid = 1'b0;
      end else if (in_valid) begin
         exp_out   = sub_ref(instate);
         exp_valid = 1'b1;
      end else exp_valid = 1'b0;
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) ref_tab[i] = sbox_math(8'(i));
      rst_n    = 1'b0;
      in_valid = 1'b1;
      instate  = '1;
      @(negedge clk);
      tick("reset0");
      tick("reset1");
      check_lit("reset_lit", 128'h0, 1'b0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick("idle_after_reset");
      in_valid = 1'b1;
      instate  = {88'h0, 40'h22E065F20F};
      tick("low_bytes");
      check_lit("low_bytes_lit", {{11{8'h63}}, 40'h93E14D8976}, 1'b1);
      instate  = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
      tick("fips");
      check_lit("fips_lit", 128'hD42711AEE0BF98F1B8B45DE51E415230, 1'b1);
      in_valid = 1'b0;
      instate  = rand128();
      tick("hold0");
      check_lit("hold_lit", 128'hD42711AEE0BF98F1B8B45DE51E415230, 1'b0);
      instate  = rand128();
      tick("hold1");
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         instate = {16{8'(i)}};
         tick("exhaustive");
         n_assert++;
         assert (outstate === {16{ref_tab[i]}}) else begin
            n_fail++;
            $error("FAIL exh_%0d observed=%h expected=%h", i, outstate, {16{ref_tab[i]}});
         end
      end
      check_lit("exh_ff", {16{8'h16}}, 1'b1);
      for (int i = 0; i < 4; i++) begin
         instate = rand128();
         tick("pre_midreset");
      end
      rst_n   = 1'b0;
      instate = rand128();
      tick("midreset");
      check_lit("midreset_lit", 128'h0, 1'b0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick("post_reset_idle");
      in_valid = 1'b1;
      instate  = 128'h00000000000000000000000000005201;
      tick("resume");
      check_lit("resume_lit", {{14{8'h63}}, 16'h007C}, 1'b1);
      for (int i = 0; i < 400; i++) begin
         rst_n    = ($urandom_range(0, 31) != 0);
         in_valid = $urandom_range(0, 2) != 0;
         instate  = rand128();
         tick("random");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
